// File: rtl/sme_ff_ctrl.sv
// sme_ff_ctrl: loads a pattern, runs the failure-function unit, publishes a double-buffered table (watchdog via SME_FF_TIMEOUT_EN)
module sme_ff_ctrl #(
  parameter int MAX_PATTERN = 8,
  parameter int BYTE        = 8,
  parameter int MAX_PAT_ADD = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pat_valid,
  input  logic [BYTE-1:0]                pat_data,
  input  logic                           pat_last,
  output logic                           pat_ready,
  output logic                           ff_req,
  output logic [MAX_PATTERN*BYTE-1:0]    ff_pattern,
  output logic [MAX_PAT_ADD-1:0]         ff_last_idx,
  input  logic                           ff_valid,
  input  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_table,
  input  logic                           match_busy,
  output logic                           tbl_valid,
  output logic                           tbl_update,
  output logic [MAX_PATTERN*BYTE-1:0]    tbl_pattern,
  output logic [MAX_PAT_ADD*MAX_PATTERN-1:0] tbl_fail,
  output logic [MAX_PAT_ADD-1:0]         tbl_last_idx,
  output logic                           err_overflow,
  output logic                           err_timeout
);
  typedef enum logic [1:0] {LOAD, CALC, RELEASE, COMMIT} state_t;
  localparam logic [MAX_PAT_ADD-1:0] CNT_MAX = MAX_PAT_ADD'(MAX_PATTERN - 1);
  state_t state, state_nxt;
  logic [MAX_PAT_ADD-1:0] cnt;
  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] shadow;
  logic hs, last, timeout, aborted;
  assign pat_ready = state == LOAD;
  assign ff_req    = state == CALC;
  assign hs        = pat_valid & pat_ready;
  assign last      = pat_last | (cnt == CNT_MAX);
`ifdef SME_FF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  assign timeout = state == CALC && !ff_valid && tcnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    tcnt        <= (reset || state != CALC) ? '0 : tcnt + 1'b1;
    err_timeout <= !reset && timeout;
    aborted     <= reset ? 1'b0 : timeout ? 1'b1 : (state == LOAD) ? 1'b0 : aborted;
  end
`else
  assign timeout     = 1'b0;
  assign aborted     = 1'b0;
  // constant 0; the comparison keeps TIMEOUT_CYC referenced in this build
  assign err_timeout = TIMEOUT_CYC < 0;
`endif
  always_ff @(posedge clk) state <= reset ? LOAD : state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    state_nxt = (hs && last) ? ((cnt == '0) ? COMMIT : CALC) : LOAD;
      CALC:    state_nxt = (ff_valid || timeout) ? RELEASE : CALC;
      RELEASE: state_nxt = ff_valid ? RELEASE : aborted ? LOAD : COMMIT;
      COMMIT:  state_nxt = match_busy ? COMMIT : LOAD;
      default: state_nxt = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      ff_pattern   <= '0;
      ff_last_idx  <= '0;
      shadow       <= '0;
      tbl_valid    <= 1'b0;
      tbl_update   <= 1'b0;
      tbl_pattern  <= '0;
      tbl_fail     <= '0;
      tbl_last_idx <= '0;
      err_overflow <= 1'b0;
    end else begin
      tbl_update   <= 1'b0;
      err_overflow <= 1'b0;
      if (hs) begin
        if (cnt == '0) ff_pattern <= '0;
        ff_pattern[cnt*BYTE +: BYTE] <= pat_data;
        cnt          <= last ? '0 : cnt + 1'b1;
        err_overflow <= cnt == CNT_MAX && !pat_last;
        if (last) ff_last_idx <= cnt;
        if (last && cnt == '0) shadow <= '0;
      end
      if (state == CALC && ff_valid) shadow <= ff_table;
      if (timeout) shadow <= '0;
      if (state == COMMIT && !match_busy) begin
        tbl_pattern  <= ff_pattern;
        tbl_fail     <= shadow;
        tbl_last_idx <= ff_last_idx;
        tbl_valid    <= 1'b1;
        tbl_update   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sme_ff_ctrl.sv
// tb_sme_ff_ctrl: directed self-checking bench for sme_ff_ctrl (default build)
module tb_sme_ff_ctrl;
  logic clk = 0, reset = 1;
  logic pat_valid = 0, pat_last = 0, ff_valid = 0, match_busy = 0;
  logic [7:0] pat_data = 0;
  logic [23:0] ff_table = 0;
  logic pat_ready, ff_req, tbl_valid, tbl_update, err_overflow, err_timeout;
  logic [63:0] ff_pattern, tbl_pattern;
  logic [2:0] ff_last_idx, tbl_last_idx;
  logic [23:0] tbl_fail;
  int n_chk = 0, n_fail = 0;
  sme_ff_ctrl dut (
    .clk(clk), .reset(reset), .pat_valid(pat_valid), .pat_data(pat_data),
    .pat_last(pat_last), .pat_ready(pat_ready), .ff_req(ff_req),
    .ff_pattern(ff_pattern), .ff_last_idx(ff_last_idx), .ff_valid(ff_valid),
    .ff_table(ff_table), .match_busy(match_busy), .tbl_valid(tbl_valid),
    .tbl_update(tbl_update), .tbl_pattern(tbl_pattern), .tbl_fail(tbl_fail),
    .tbl_last_idx(tbl_last_idx), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    pat_valid = 1; pat_data = d; pat_last = l;
    tick;
    pat_valid = 0; pat_last = 0;
  endtask
  // DP unit: raise ff_valid with the table, hold it hold+1 cycles, then drop it
  task automatic respond(input logic [23:0] t, input int hold);
    ff_table = t; ff_valid = 1;
    tick;
    check("req_drop", ff_req, 0);
    for (int i = 0; i < hold; i++) tick;
    ff_valid = 0;
    tick;
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end
  initial begin
    tick; tick;
    reset = 0;
    check("rst_ready", pat_ready, 1);
    check("rst_req", ff_req, 0);
    check("rst_valid", tbl_valid, 0);
    check("rst_update", tbl_update, 0);
    check("rst_ovf", err_overflow, 0);
    check("rst_tmo", err_timeout, 0);
    check("rst_tblpat", tbl_pattern, 0);
    check("rst_lidx", ff_last_idx, 0);
    // ABAB through the DP unit
    send(8'h41, 0); send(8'h42, 0); send(8'h41, 0);
    check("abab_req_pre", ff_req, 0);
    send(8'h42, 1);
    check("abab_req", ff_req, 1);
    check("abab_lidx", ff_last_idx, 3);
    check("abab_ready", pat_ready, 0);
    check("abab_ffpat", ff_pattern, 64'h42414241);
    tick; tick; tick;
    check("abab_req_hold", ff_req, 1);
    respond(24'h000440, 1);
    check("abab_upd_pre", tbl_update, 0);
    tick;
    check("abab_upd", tbl_update, 1);
    check("abab_tblpat", tbl_pattern, 64'h42414241);
    check("abab_tlidx", tbl_last_idx, 3);
    check("abab_fail", tbl_fail, 24'h000440);
    check("abab_valid", tbl_valid, 1);
    tick;
    check("abab_upd_once", tbl_update, 0);
    check("abab_ready2", pat_ready, 1);
    // single byte skips the DP unit
    send(8'h55, 1);
    check("one_req", ff_req, 0);
    check("one_upd_pre", tbl_update, 0);
    tick;
    check("one_upd", tbl_update, 1);
    check("one_fail", tbl_fail, 0);
    check("one_tlidx", tbl_last_idx, 0);
    check("one_tblpat", tbl_pattern, 64'h55);
    // overflow: eight bytes, none marked last
    for (int i = 1; i <= 7; i++) send(8'(i), 0);
    check("ovf_early", err_overflow, 0);
    check("ovf_ready7", pat_ready, 1);
    send(8'h08, 0);
    check("ovf_pulse", err_overflow, 1);
    check("ovf_lidx", ff_last_idx, 7);
    check("ovf_ready", pat_ready, 0);
    check("ovf_req", ff_req, 1);
    check("ovf_ffpat", ff_pattern, 64'h0807060504030201);
    tick;
    check("ovf_once", err_overflow, 0);
    // matcher busy holds the old table in place
    match_busy = 1;
    respond(24'h000000, 0);
    tick; tick; tick;
    check("busy_upd", tbl_update, 0);
    check("busy_tblpat", tbl_pattern, 64'h55);
    check("busy_valid", tbl_valid, 1);
    check("busy_ready", pat_ready, 0);
    match_busy = 0;
    tick;
    check("busy_rel_upd", tbl_update, 1);
    check("busy_rel_pat", tbl_pattern, 64'h0807060504030201);
    check("busy_rel_lidx", tbl_last_idx, 7);
    tick;
    // new pattern clears stale bytes, then reset during CALC
    send(8'h11, 0); send(8'h22, 1);
    check("clr_ffpat", ff_pattern, 64'h2211);
    check("clr_req", ff_req, 1);
    reset = 1;
    tick;
    reset = 0;
    check("mrst_req", ff_req, 0);
    check("mrst_valid", tbl_valid, 0);
    check("mrst_ready", pat_ready, 1);
    check("mrst_tblpat", tbl_pattern, 0);
    check("mrst_ffpat", ff_pattern, 0);
    send(8'h77, 1);
    check("mrst_cnt0_req", ff_req, 0);
    tick;
    check("mrst_upd", tbl_update, 1);
    check("mrst_tblpat2", tbl_pattern, 64'h77);
    check("mrst_tlidx", tbl_last_idx, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
